// File: rtl/seq_fxp_multiplier.sv
// Sequential unsigned fixed-point multiplier, radix-2 shift-add.
// Operands and product share the Q(WIDTH-FRAC).FRAC format; the product is
// truncated to WIDTH bits and saturates to all ones on overflow.
// Handshake: start is sampled in IDLE, operands are latched one cycle later,
// and valid pulses once per accepted start after a fixed latency.
//
// Ports:
//   clk     rising-edge clock
//   sclr_n  synchronous clear, active low (overrides start)
//   start   request, sampled only in IDLE
//   data_A  multiplicand, latched in LOAD
//   data_B  multiplier, latched in LOAD
//   valid   one-cycle pulse, q/ovf valid
//   ovf     product exceeds the q range
//   busy    high in LOAD and CALC
//   q       product, Q(WIDTH-FRAC).FRAC
module seq_fxp_multiplier #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned FRAC  = 6
) (
    input  logic             clk,
    input  logic             sclr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_A,
    input  logic [WIDTH-1:0] data_B,
    output logic             valid,
    output logic             ovf,
    output logic             busy,
    output logic [WIDTH-1:0] q
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    cnt;

    logic [PW-1:0]    partial_c;
    logic [PW-1:0]    acc_sum_c;
    logic             ovf_c;
    logic [WIDTH-1:0] q_c;

    // Partial product for the current multiplier bit and the running sum.
    // The final sum is used directly for the result so q/ovf land with valid.
    always_comb begin
        partial_c = '0;
        if (reg_b[0]) begin
            partial_c = PW'(reg_a) << cnt;
        end
        acc_sum_c = acc + partial_c;
        ovf_c     = |acc_sum_c[PW-1:FRAC+WIDTH];
        q_c       = ovf_c ? '1 : acc_sum_c[FRAC+WIDTH-1:FRAC];
    end

    // Control FSM and datapath registers; all outputs registered.
    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            state <= S_IDLE;
            reg_a <= '0;
            reg_b <= '0;
            acc   <= '0;
            cnt   <= '0;
            valid <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    valid <= 1'b0;
                    if (start) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    reg_a <= data_A;
                    reg_b <= data_B;
                    acc   <= '0;
                    cnt   <= '0;
                    ovf   <= 1'b0;
                    state <= S_CALC;
                end
                S_CALC: begin
                    acc   <= acc_sum_c;
                    reg_b <= reg_b >> 1;
                    cnt   <= cnt + CW'(1);
                    // Always runs all WIDTH bits: fixed latency, no early exit.
                    if (cnt == CNT_LAST) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        valid <= 1'b1;
                        q     <= q_c;
                        ovf   <= ovf_c;
                    end
                end
                S_DONE: begin
                    valid <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
